clamp_select_stage: RTL and testbench

Registered select-and-clamp stage for signed datapath words. It picks one of several packed signed lanes, registers it, and limits it to a symmetric window ±`clamp`. It then presents the result with a valid strobe. It sits between the voltage-producing arithmetic (e.g. inverse Clarke outputs) and the PWM formatting logic. It guarantees that no commanded value exceeds the configured magnitude.

---
 rtl/clamp_select_stage.sv | 90 +++++++++
 tb/tb_clamp_select_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/clamp_select_stage.sv
// Registered lane select followed by a symmetric +/-clamp limiter.
// Two register stages: capture (stage 1) and clamp/hold (stage 2).
module clamp_select_stage #(
    parameter int DWIDTH   = 16,
    parameter int SELWIDTH = 2
) (
    input  logic                              c,
    input  logic                              rst_n,
    input  logic [DWIDTH*(2**SELWIDTH)-1:0]   d,
    input  logic [SELWIDTH-1:0]               sel,
    input  logic                              dv,
    input  logic [DWIDTH-1:0]                 clamp,
    output logic [DWIDTH-1:0]                 q,
    output logic                              qv,
    output logic                              hi,
    output logic                              lo
);

    localparam int LANES = 2**SELWIDTH;
    localparam logic [DWIDTH-1:0] MAX_POS = {1'b0, {(DWIDTH-1){1'b1}}};

    logic [DWIDTH-1:0] lane [LANES];
    logic [DWIDTH-1:0] sel_val;

    logic [DWIDTH-1:0] x1;
    logic              v1;
    logic [DWIDTH-1:0] clamp1;

    logic [DWIDTH-1:0]        lim;
    logic signed [DWIDTH:0]   x_ext;
    logic signed [DWIDTH:0]   lim_pos;
    logic signed [DWIDTH:0]   lim_neg;
    logic [DWIDTH-1:0]        q_nxt;
    logic                     hi_nxt;
    logic                     lo_nxt;

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            lane[k] = d[k*DWIDTH +: DWIDTH];
        end
        sel_val = lane[sel];
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            x1     <= '0;
            v1     <= 1'b0;
            clamp1 <= '0;
        end else begin
            x1     <= sel_val;
            v1     <= dv;
            clamp1 <= clamp;
        end
    end

    // One extra bit keeps -lim representable and the compares free of wrap-around.
    always_comb begin
        lim     = (clamp1 > MAX_POS) ? MAX_POS : clamp1;
        x_ext   = {x1[DWIDTH-1], x1};
        lim_pos = {1'b0, lim};
        lim_neg = -lim_pos;
        q_nxt   = x1;
        hi_nxt  = 1'b0;
        lo_nxt  = 1'b0;
        if (x_ext > lim_pos) begin
            q_nxt  = lim;
            hi_nxt = 1'b1;
        end else if (x_ext < lim_neg) begin
            q_nxt  = lim_neg[DWIDTH-1:0];
            lo_nxt = 1'b1;
        end
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            q  <= '0;
            hi <= 1'b0;
            lo <= 1'b0;
            qv <= 1'b0;
        end else begin
            qv <= v1;
            if (v1) begin
                q  <= q_nxt;
                hi <= hi_nxt;
                lo <= lo_nxt;
            end
        end
    end

endmodule

// File: tb/tb_clamp_select_stage.sv
// Scoreboard bench for clamp_select_stage: driver pushes model results,
// a negedge monitor pops them on qv and checks hold values otherwise.
module tb_clamp_select_stage;

    logic        c;
    logic        rst_n;
    logic [63:0] d;
    logic [1:0]  sel;
    logic        dv;
    logic [15:0] clamp;
    logic [15:0] q;
    logic        qv;
    logic        hi;
    logic        lo;

    clamp_select_stage #(.DWIDTH(16), .SELWIDTH(2)) dut (
        .c(c), .rst_n(rst_n), .d(d), .sel(sel), .dv(dv), .clamp(clamp),
        .q(q), .qv(qv), .hi(hi), .lo(lo)
    );

    typedef struct {
        logic [15:0] q;
        logic        hi;
        logic        lo;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t last;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   running = 0;

    initial begin
        c = 1'b0;
        forever #5 c = ~c;
    end

    always @(posedge c) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: saturate the magnitude limit, then clip symmetrically.
    function automatic exp_t model(input logic [63:0] dd, input logic [1:0] s, input logic [15:0] cl);
        exp_t        e;
        logic [15:0] raw;
        int          x;
        int          lim;
        int          r;
        raw  = 16'((dd >> (int'(s) * 16)) & 64'hFFFF);
        x    = int'($signed(raw));
        lim  = (int'(cl) > 32767) ? 32767 : int'(cl);
        e.hi = 1'b0;
        e.lo = 1'b0;
        if (x > lim) begin
            r = lim;
            e.hi = 1'b1;
        end else if (x < -lim) begin
            r = -lim;
            e.lo = 1'b1;
        end else begin
            r = x;
        end
        e.q   = 16'(r);
        e.due = 0;
        return e;
    endfunction

    task automatic send(input logic [63:0] dd, input logic [1:0] s, input logic [15:0] cl);
        exp_t e;
        @(posedge c);
        #2;
        d     = dd;
        sel   = s;
        clamp = cl;
        dv    = 1'b1;
        e     = model(dd, s, cl);
        e.due = cyc + 2;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge c);
            #2;
            dv    = 1'b0;
            d     = {$urandom, $urandom};
            sel   = 2'($urandom);
            clamp = 16'($urandom);
        end
    endtask

    task automatic do_reset();
        @(posedge c);
        #2;
        rst_n = 1'b0;
        dv    = 1'b0;
        sb.delete();
        last.q  = '0;
        last.hi = 1'b0;
        last.lo = 1'b0;
        #1;
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_qv", 32'(qv), 32'h0);
        chk("rst_hi", 32'(hi), 32'h0);
        chk("rst_lo", 32'(lo), 32'h0);
        repeat (2) @(posedge c);
        #2;
        rst_n = 1'b1;
    endtask

    always @(negedge c) begin
        if (running) begin
            if (qv) begin
                if (sb.size() == 0) begin
                    chk("spurious_qv", 32'(qv), 32'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("q", 32'(q), 32'(e.q));
                    chk("hi", 32'(hi), 32'(e.hi));
                    chk("lo", 32'(lo), 32'(e.lo));
                    chk("latency", 32'(cyc), 32'(e.due));
                    last = e;
                end
            end else begin
                chk("hold_q", 32'(q), 32'(last.q));
                chk("hold_hi", 32'(hi), 32'(last.hi));
                chk("hold_lo", 32'(lo), 32'(last.lo));
            end
        end
    end

    function automatic logic [15:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 16'h8000;
            1: return 16'h7FFF;
            2: return 16'h0000;
            3: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic logic [15:0] pick_clamp();
        case ($urandom_range(0, 6))
            0: return 16'h0000;
            1: return 16'h7FFF;
            2: return 16'h8000;
            3: return 16'hFFFF;
            4: return 16'($urandom_range(0, 255));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        logic [63:0] lanes;
        int          waited;
        rst_n = 1'b0;
        dv    = 1'b0;
        d     = '0;
        sel   = '0;
        clamp = '0;
        last.q  = '0;
        last.hi = 1'b0;
        last.lo = 1'b0;
        #1;
        chk("init_q", 32'(q), 32'h0);
        chk("init_qv", 32'(qv), 32'h0);
        repeat (2) @(posedge c);
        #2;
        rst_n   = 1'b1;
        running = 1;

        // Pass-through and symmetric negative limit.
        lanes = {16'h0003, 16'h8000, 16'h1234, 16'hFF00};
        send(lanes, 2'd0, 16'h7FFF);
        send(lanes, 2'd1, 16'h7FFF);
        send(lanes, 2'd3, 16'h7FFF);
        idle(2);
        send(lanes, 2'd2, 16'h7FFF);
        idle(3);

        // Clamping at 0x1000.
        send({48'h0, 16'h2000}, 2'd0, 16'h1000);
        send({32'h0, 16'hC000, 16'h0}, 2'd1, 16'h1000);
        send({16'h0, 16'h0FFF, 32'h0}, 2'd2, 16'h1000);
        send({16'hF000, 48'h0}, 2'd3, 16'h1000);
        idle(3);

        // Oversized and zero clamp.
        send({48'h0, 16'h7FFF}, 2'd0, 16'hFFFF);
        send({48'h0, 16'h0001}, 2'd0, 16'h0000);
        send({48'h0, 16'h0000}, 2'd0, 16'h0000);
        send({48'h0, 16'hFFFF}, 2'd0, 16'h0000);
        idle(6);

        // Reset with samples in flight, then quiet release.
        send({$urandom, $urandom}, 2'($urandom), 16'h7FFF);
        send({$urandom, $urandom}, 2'($urandom), 16'h7FFF);
        do_reset();
        idle(5);

        // Randomized traffic with bursts and gaps.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                lanes = {pick_val(), pick_val(), pick_val(), pick_val()};
                send(lanes, 2'($urandom), pick_clamp());
            end else begin
                idle($urandom_range(1, 3));
            end
        end
        idle(4);

        waited = 0;
        while (sb.size() != 0 && waited < 20) begin
            @(posedge c);
            waited++;
        end
        chk("drain_left", 32'(sb.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
